// File: rtl/cpu_mul_combine_pkg.sv
// Shared CPU definitions used by the multiply combine stage: register index type
// and common constants.
package cpu_mul_combine_pkg;

    localparam int DST_W_DEF = 5;
    localparam int CNT_W_DEF = 32;

    typedef logic [DST_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/cpu_mul_combine_if.sv
// Bundle of the M-stage inputs, pipeline control, hazard port and W-stage results.
// Handshake: a result is committed by the consumer only in a cycle where
// W_mul_vld=1 and stall=0; flush kills everything in flight at the next edge.
interface cpu_mul_combine_if #(
    parameter int DST_W = cpu_mul_combine_pkg::DST_W_DEF,
    parameter int CNT_W = cpu_mul_combine_pkg::CNT_W_DEF
);

    logic             M_mul_vld;
    logic [31:0]      M_mul_cell_p1;
    logic [31:0]      M_mul_cell_p2;
    logic [31:0]      M_mul_cell_p3;
    logic [DST_W-1:0] M_mul_dst;
    logic             stall;
    logic             flush;
    logic [DST_W-1:0] hz_query;
    logic             W_mul_vld;
    logic [31:0]      W_mul_result;
    logic [DST_W-1:0] W_mul_dst;
    logic             hz_hit;
    logic [CNT_W-1:0] mul_count;

    modport master (
        output M_mul_vld, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_dst,
        output stall, flush, hz_query,
        input  W_mul_vld, W_mul_result, W_mul_dst, hz_hit, mul_count
    );

    modport slave (
        input  M_mul_vld, M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_dst,
        input  stall, flush, hz_query,
        output W_mul_vld, W_mul_result, W_mul_dst, hz_hit, mul_count
    );

endinterface

// File: rtl/cpu_mul_combine_stage.sv
// Generic pipeline register: valid bit plus payload, with enable (hold when low)
// and a clear that drops the valid bit but leaves the payload untouched.
module cpu_mul_combine_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          vld_i,
    input  logic [PW-1:0] data_i,
    output logic          vld_o,
    output logic [PW-1:0] data_o
);

    logic          vld_q, vld_d;
    logic [PW-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (en_i) begin
            vld_d  = vld_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/cpu_mul_combine.sv
// Assembles the low 32 bits of a 32x32 product from three 16x16 partial products
// over two pipeline stages (A, W), with hazard compare and a retired-op counter.
module cpu_mul_combine
    import cpu_mul_combine_pkg::*;
#(
    parameter int DST_W = DST_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    cpu_mul_combine_if.slave  bus
);

    localparam int A_PW = 32 + 16 + DST_W;
    localparam int W_PW = 32 + DST_W;

    logic             adv;
    logic [15:0]      cross_d;
    logic             a_vld;
    logic [A_PW-1:0]  a_data;
    logic [31:0]      a_p1;
    logic [15:0]      a_cross;
    logic [DST_W-1:0] a_dst;
    logic [31:0]      result_d;
    logic             w_vld;
    logic [W_PW-1:0]  w_data;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign adv = !bus.stall;

    // Only the low halves of the cross terms land inside the low 32-bit word.
    assign cross_d = bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];

    cpu_mul_combine_stage #(.PW(A_PW)) u_stage_a (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_i   (adv),
        .clr_i  (bus.flush),
        .vld_i  (bus.M_mul_vld),
        .data_i ({bus.M_mul_cell_p1, cross_d, bus.M_mul_dst}),
        .vld_o  (a_vld),
        .data_o (a_data)
    );

    assign {a_p1, a_cross, a_dst} = a_data;
    assign result_d = a_p1 + {a_cross, 16'h0000};

    cpu_mul_combine_stage #(.PW(W_PW)) u_stage_w (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_i   (adv),
        .clr_i  (bus.flush),
        .vld_i  (a_vld),
        .data_i ({result_d, a_dst}),
        .vld_o  (w_vld),
        .data_o (w_data)
    );

    assign bus.W_mul_vld = w_vld;
    assign {bus.W_mul_result, bus.W_mul_dst} = w_data;

    always_comb begin
        cnt_d = cnt_q;
        if (w_vld && !bus.stall && !bus.flush) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.mul_count = cnt_q;

    // Register zero is hard-wired, so it can never be a real dependency.
    assign bus.hz_hit = (bus.hz_query != DST_W'(REG_ZERO)) &&
                        ((a_vld && (a_dst == bus.hz_query)) ||
                         (w_vld && (bus.W_mul_dst == bus.hz_query)));

endmodule

// File: tb/tb_cpu_mul_combine.sv
// Directed bench for cpu_mul_combine: a 32-bit-counter instance plus a 4-bit-counter
// instance sharing the same stimulus for the wrap check.
module tb_cpu_mul_combine;
    import cpu_mul_combine_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cpu_mul_combine_if #(.DST_W(5), .CNT_W(32)) if0 ();
    cpu_mul_combine_if #(.DST_W(5), .CNT_W(4))  if4 ();

    cpu_mul_combine #(.DST_W(5), .CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    cpu_mul_combine #(.DST_W(5), .CNT_W(4)) dut_w4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if4.slave)
    );

    assign if4.M_mul_vld     = if0.M_mul_vld;
    assign if4.M_mul_cell_p1 = if0.M_mul_cell_p1;
    assign if4.M_mul_cell_p2 = if0.M_mul_cell_p2;
    assign if4.M_mul_cell_p3 = if0.M_mul_cell_p3;
    assign if4.M_mul_dst     = if0.M_mul_dst;
    assign if4.stall         = if0.stall;
    assign if4.flush         = if0.flush;
    assign if4.hz_query      = if0.hz_query;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_cnt = '0;
    logic [36:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] p1, input logic [31:0] p2,
                            input logic [31:0] p3, input logic [4:0] dst);
        if0.M_mul_vld     = 1'b1;
        if0.M_mul_cell_p1 = p1;
        if0.M_mul_cell_p2 = p2;
        if0.M_mul_cell_p3 = p3;
        if0.M_mul_dst     = dst;
    endtask

    task automatic idle();
        if0.M_mul_vld = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        if0.M_mul_cell_p1 = '0;
        if0.M_mul_cell_p2 = '0;
        if0.M_mul_cell_p3 = '0;
        if0.M_mul_dst     = '0;
        if0.stall         = 1'b0;
        if0.flush         = 1'b0;
        if0.hz_query      = 5'd3;
        #2;
        n_vec++;
        if (if0.W_mul_vld !== 1'b0 || if0.W_mul_result !== 32'h0 || if0.W_mul_dst !== 5'd0) begin
            n_err++;
            $display("FAIL reset_w: vld=%b res=%h dst=%0d, want 0/0/0", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
        end
        n_vec++;
        if (if0.mul_count !== 32'd0 || if0.hz_hit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt_hz: cnt=%0d hz=%b, want 0/0", if0.mul_count, if0.hz_hit);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_op(32'h8, 32'hA, 32'hC, 5'd3);
        tick();
        idle();
        tick();
        n_vec++;
        if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h00160008 || if0.W_mul_dst !== 5'd3) begin
            n_err++;
            $display("FAIL basic: vld=%b res=%h dst=%0d, want 1/00160008/3", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
        end
        n_vec++;
        if (if0.mul_count !== exp_cnt) begin
            n_err++;
            $display("FAIL basic_cnt_before: cnt=%0d, want %0d", if0.mul_count, exp_cnt);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (if0.mul_count !== exp_cnt || if0.W_mul_vld !== 1'b0) begin
            n_err++;
            $display("FAIL basic_cnt_after: cnt=%0d vld=%b, want %0d/0", if0.mul_count, if0.W_mul_vld, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        drive_op(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd9);
        tick();
        idle();
        tick();
        n_vec++;
        if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h00000001 || if0.W_mul_dst !== 5'd9) begin
            n_err++;
            $display("FAIL wrap: vld=%b res=%h dst=%0d, want 1/00000001/9", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (if0.mul_count !== exp_cnt) begin
            n_err++;
            $display("FAIL wrap_cnt: cnt=%0d, want %0d", if0.mul_count, exp_cnt);
        end
    endtask

    task automatic test_stall();
        // upper halves of p2/p3 are junk and must not reach the result
        drive_op(32'h00001234, 32'hABCD0002, 32'h12340004, 5'd12);
        tick();
        idle();
        if0.stall = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            n_vec++;
            if (if0.W_mul_vld !== 1'b0) begin
                n_err++;
                $display("FAIL stall_early c%0d: vld=%b, want 0", c, if0.W_mul_vld);
            end
            tick();
        end
        if0.stall = 1'b0;
        tick();
        n_vec++;
        if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h00061234 || if0.W_mul_dst !== 5'd12) begin
            n_err++;
            $display("FAIL stall_result: vld=%b res=%h dst=%0d, want 1/00061234/12", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
        end
        if0.stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h00061234 || if0.mul_count !== exp_cnt) begin
                n_err++;
                $display("FAIL stall_hold c%0d: vld=%b res=%h cnt=%0d, want 1/00061234/%0d", c, if0.W_mul_vld, if0.W_mul_result, if0.mul_count, exp_cnt);
            end
        end
        if0.stall = 1'b0;
        tick();
        exp_cnt++;
        n_vec++;
        if (if0.mul_count !== exp_cnt || if0.W_mul_vld !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: cnt=%0d vld=%b, want %0d/0", if0.mul_count, if0.W_mul_vld, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drive_op(32'h11, 32'h1, 32'h1, 5'd4);
        tick();
        drive_op(32'h22, 32'h2, 32'h2, 5'd5);
        if0.stall = 1'b1;
        if0.flush = 1'b1;
        tick();
        idle();
        if0.stall = 1'b0;
        if0.flush = 1'b0;
        for (int c = 2; c < 6; c++) begin
            n_vec++;
            if (if0.W_mul_vld !== 1'b0 || if0.mul_count !== exp_cnt) begin
                n_err++;
                $display("FAIL flush_stall c%0d: vld=%b cnt=%0d, want 0/%0d", c, if0.W_mul_vld, if0.mul_count, exp_cnt);
            end
            tick();
        end
        drive_op(32'h33, 32'h3, 32'h3, 5'd6);
        tick();
        idle();
        tick();
        n_vec++;
        if (if0.W_mul_vld !== 1'b1) begin
            n_err++;
            $display("FAIL flush_retire_pre: vld=%b, want 1", if0.W_mul_vld);
        end
        if0.flush = 1'b1;
        tick();
        if0.flush = 1'b0;
        n_vec++;
        if (if0.W_mul_vld !== 1'b0 || if0.mul_count !== exp_cnt) begin
            n_err++;
            $display("FAIL flush_retire: vld=%b cnt=%0d, want 0/%0d", if0.W_mul_vld, if0.mul_count, exp_cnt);
        end
    endtask

    task automatic test_hazard();
        if0.hz_query = 5'd7;
        drive_op(32'h1, 32'h2, 32'h3, 5'd7);
        #1;
        n_vec++;
        if (if0.hz_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hz_c0: hit=%b, want 0", if0.hz_hit);
        end
        tick();
        idle();
        n_vec++;
        if (if0.hz_hit !== 1'b1) begin
            n_err++;
            $display("FAIL hz_c1_a: hit=%b, want 1", if0.hz_hit);
        end
        if0.hz_query = 5'd6;
        #1;
        n_vec++;
        if (if0.hz_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hz_c1_other: hit=%b, want 0", if0.hz_hit);
        end
        if0.hz_query = 5'd7;
        tick();
        n_vec++;
        if (if0.hz_hit !== 1'b1) begin
            n_err++;
            $display("FAIL hz_c2_w: hit=%b, want 1", if0.hz_hit);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (if0.hz_hit !== 1'b0) begin
            n_err++;
            $display("FAIL hz_c3: hit=%b, want 0", if0.hz_hit);
        end
        if0.hz_query = 5'd0;
        drive_op(32'h5, 32'h0, 32'h0, 5'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (if0.hz_hit !== 1'b0) begin
                n_err++;
                $display("FAIL hz_r0 c%0d: hit=%b, want 0", c, if0.hz_hit);
            end
            if (c == 2) begin
                n_vec++;
                if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h5 || if0.W_mul_dst !== 5'd0) begin
                    n_err++;
                    $display("FAIL hz_r0_flow: vld=%b res=%h dst=%0d, want 1/00000005/0", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
                end
            end
            tick();
            idle();
        end
        exp_cnt++;
        n_vec++;
        if (if0.mul_count !== exp_cnt) begin
            n_err++;
            $display("FAIL hz_r0_cnt: cnt=%0d, want %0d", if0.mul_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        if0.hz_query = 5'd9;
        drive_op(32'h7, 32'h1, 32'h1, 5'd9);
        tick();
        drive_op(32'h8, 32'h1, 32'h1, 5'd10);
        tick();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        exp_cnt = '0;
        n_vec++;
        if (if0.W_mul_vld !== 1'b0 || if0.W_mul_result !== 32'h0 || if0.W_mul_dst !== 5'd0 ||
            if0.mul_count !== 32'd0 || if0.hz_hit !== 1'b0 || if4.mul_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid: vld=%b res=%h dst=%0d cnt=%0d hz=%b cnt4=%0d, want all 0",
                     if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst, if0.mul_count, if0.hz_hit, if4.mul_count);
        end
        #2;
        reset_n = 1'b1;
        drive_op(32'h3, 32'h1, 32'h1, 5'd2);
        tick();
        idle();
        tick();
        n_vec++;
        if (if0.W_mul_vld !== 1'b1 || if0.W_mul_result !== 32'h00020003 || if0.W_mul_dst !== 5'd2) begin
            n_err++;
            $display("FAIL reset_after: vld=%b res=%h dst=%0d, want 1/00020003/2", if0.W_mul_vld, if0.W_mul_result, if0.W_mul_dst);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (if0.mul_count !== exp_cnt) begin
            n_err++;
            $display("FAIL reset_after_cnt: cnt=%0d, want %0d", if0.mul_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] e;
        logic [31:0] p1, p3, res;
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_cnt = '0;
        exp_q.delete();
        for (int c = 0; c < 19; c++) begin
            if (c < 17) begin
                p1  = 32'h1000 + 32'(c);
                p3  = 32'(c) * 3;
                res = p1 + ((32'(c) * 4) << 16);
                drive_op(p1, 32'hFFFF0000 | 32'(c), p3, 5'(c));
                exp_q.push_back({5'(c), res});
            end else begin
                idle();
            end
            if (c >= 2) begin
                e = exp_q.pop_front();
                n_vec++;
                if (if0.W_mul_vld !== 1'b1 || {if0.W_mul_dst, if0.W_mul_result} !== e) begin
                    n_err++;
                    $display("FAIL b2b c%0d: vld=%b dst=%0d res=%h, want 1/%0d/%h",
                             c, if0.W_mul_vld, if0.W_mul_dst, if0.W_mul_result, e[36:32], e[31:0]);
                end
            end else begin
                n_vec++;
                if (if0.W_mul_vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_empty c%0d: vld=%b, want 0", c, if0.W_mul_vld);
                end
            end
            tick();
        end
        n_vec++;
        if (if0.mul_count !== 32'd17 || if0.W_mul_vld !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_cnt32: cnt=%0d vld=%b, want 17/0", if0.mul_count, if0.W_mul_vld);
        end
        n_vec++;
        if (if4.mul_count !== 4'd1) begin
            n_err++;
            $display("FAIL cnt4_wrap: cnt=%0d, want 1", if4.mul_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_flush();
        test_hazard();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
